floating_point: RTL and testbench
=================================

Name: floating_point

Overview:
- Pipelined IEEE-754 binary16 (half-precision) arithmetic unit supporting add, subtract, multiply and divide.
- The operation is chosen per cycle by a 2-bit select.
- It is the shared FP datapath of the robotic-manipulator compute path: one result per clock with a fixed 3-cycle latency.

Parameters:
- LATENCY, 3, clock cycles from operand sampling to result on fpResult. Fixed; not intended for override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- areset  input  1  reset, synchronous and active-high (name kept per codebase convention despite being synchronous).
- a  input  16  operand A, binary16 (sign[15], exp[14:10], frac[9:0]).
- b  input  16  operand B, binary16.
- selectFPOperation  input  2  operation select: 00 = a+b, 01 = a-b, 10 = a*b, 11 = a/b.
- fpResult  output  16  registered binary16 result.

Behaviour:
- Reset: when areset is high at a rising edge, all pipeline registers clear and fpResult = 16'h0000 on the following cycle. The pipeline refills normally after reset deasserts.
- Pipeline and latency:
  - a, b and selectFPOperation are sampled at edge N. The result appears on fpResult after edge N+3.
  - The unit accepts a new operation every cycle.
  - The select value travels with its operands, so changing the select mid-flight does not corrupt in-flight operations.
- Stage split (suggested):
  - S1: unpack, classify, align or compute the exponent.
  - S2: mantissa add/sub, multiply or divide.
  - S3: normalize, round, pack.
- Number handling:
  - Subnormal inputs are treated as signed zero.
  - Subnormal results flush to signed zero.
  - Rounding is round-to-nearest, ties-to-even, using guard/round/sticky bits.
  - Overflow produces signed infinity (16'h7C00 / 16'hFC00).
- Special values:
  - Any NaN input produces canonical NaN 16'h7E00.
  - inf-inf (effective subtraction), 0*inf, 0/0 and inf/inf all produce 16'h7E00.
  - x/0 with x nonzero and finite produces signed infinity; the result sign is sign(a) XOR sign(b).
  - Finite/inf produces signed zero.
  - inf op finite follows IEEE semantics.
- Signs and zeros:
  - Subtraction is addition with b's sign inverted.
  - An exact zero sum is +0 (16'h0000), except (-0)+(-0), which gives 16'h8000.
  - For multiply and divide, the result sign is sign(a) XOR sign(b), including zero and infinity results.
- Width rules:
  - Significands are 11 bits with the hidden bit.
  - The product is 22 bits.
  - The quotient is at least 14 bits (11 plus guard/round/sticky). The sticky bit is set from a nonzero remainder.
  - Exponent arithmetic uses a signed 7-bit or wider intermediate to detect underflow and overflow.
- The implementation is free of latches. A combinational divider inside a stage is acceptable.

Test Plan:
- Reset: hold areset high for 2 cycles → fpResult = 16'h0000; after release with a = b = 0, sel = 00 → fpResult stays 16'h0000.
- Basic ops: a = b = 16'h4100 (2.5), applied 3 cycles for each sel in turn:
  - sel = 00 → 16'h4500 (5.0)
  - sel = 01 → 16'h0000 (+0)
  - sel = 10 → 16'h4640 (6.25)
  - sel = 11 → 16'h3C00 (1.0)
  - Check each result arrives exactly 3 cycles after sampling.
- Back-to-back pipelining: change sel every cycle with a = b = 16'h4100 → fpResult shows 4500, 0000, 4640, 3C00 on consecutive cycles, 3-cycle offset.
- Rounding: 16'h3C00 + 16'h1000 (1 + 2^-11, a tie) → 16'h3C00; 16'h3C00 + 16'h1001 → 16'h3C01.
- Overflow and special values:
  - 16'h7BFF + 16'h7BFF → 16'h7C00
  - 16'h3C00 / 16'h0000 → 16'h7C00
  - 16'h0000 / 16'h0000 → 16'h7E00
  - 16'h7E00 * 16'h3C00 → 16'h7E00
  - 16'hBC00 * 16'h4000 → 16'hC000
- Reset mid-operation: issue an op, assert areset one cycle later → fpResult = 16'h0000 and no stale result emerges after reset.

Source files
------------

// File: rtl/floating_point.sv
// Pipelined binary16 add/sub/mul/div unit: input register, then classify/align,
// mantissa op, and normalize/round/pack stages. Subnormals flush to signed zero.
module floating_point #(
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        areset,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [1:0]  selectFPOperation,
   output logic [15:0] fpResult
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   localparam logic [15:0] QNAN = 16'h7E00;
   localparam logic [14:0] INF  = 15'h7C00;

   // ---------------- input register ----------------
   op_e               in_op;
   logic [15:0]       in_a, in_b;
   logic [LATENCY-1:0] vld;

   always_ff @(posedge clk) begin
      if (areset) begin
         in_a  <= '0;
         in_b  <= '0;
         in_op <= OP_ADD;
         vld   <= '0;
      end else begin
         in_a  <= a;
         in_b  <= b;
         in_op <= op_e'(selectFPOperation);
         vld   <= {vld[LATENCY-2:0], 1'b1};
      end
   end

   // ---------------- stage 1: unpack, classify, align / exponent ----------------
   logic              sa, sb, sbe, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
   logic [4:0]        ea, eb, e_big, d;
   logic [10:0]       ma, mb, m_big, m_small;
   logic [43:0]       ext;
   logic              c1_sub, c1_spec, c1_rs, c1_zs;
   logic [15:0]       c1_spv;
   logic signed [9:0] c1_exp;
   logic [13:0]       c1_x, c1_y;

   always_comb begin
      sa      = in_a[15];
      sb      = in_b[15];
      ea      = in_a[14:10];
      eb      = in_b[14:10];
      a_zero  = (ea == 5'd0);
      b_zero  = (eb == 5'd0);
      a_inf   = (ea == 5'h1f) && (in_a[9:0] == '0);
      b_inf   = (eb == 5'h1f) && (in_b[9:0] == '0);
      a_nan   = (ea == 5'h1f) && (in_a[9:0] != '0);
      b_nan   = (eb == 5'h1f) && (in_b[9:0] != '0);
      ma      = a_zero ? '0 : {1'b1, in_a[9:0]};
      mb      = b_zero ? '0 : {1'b1, in_b[9:0]};
      sbe     = sb ^ (in_op == OP_SUB);
      a_big   = {ea, ma} >= {eb, mb};
      e_big   = a_big ? ea : eb;
      m_big   = a_big ? ma : mb;
      m_small = a_big ? mb : ma;
      d       = a_big ? ea - eb : eb - ea;
      // smaller significand gets 3 extra low bits; everything shifted past them ORs into the LSB
      ext     = {m_small, 33'd0} >> d;

      c1_sub  = 1'b0;
      c1_spec = 1'b0;
      c1_spv  = QNAN;
      c1_rs   = 1'b0;
      c1_zs   = 1'b0;
      c1_exp  = '0;
      c1_x    = '0;
      c1_y    = '0;

      case (in_op)
         OP_ADD, OP_SUB: begin
            c1_sub = sa ^ sbe;
            c1_rs  = a_big ? sa : sbe;
            c1_zs  = sa & sbe;
            c1_exp = $signed({5'd0, e_big});
            c1_x   = {m_big, 3'b000};
            c1_y   = ext[43:30] | {13'd0, |ext[29:0]};
            if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) begin
               c1_spec = 1'b1;
               c1_spv  = QNAN;
            end else if (a_inf) begin
               c1_spec = 1'b1;
               c1_spv  = {sa, INF};
            end else if (b_inf) begin
               c1_spec = 1'b1;
               c1_spv  = {sbe, INF};
            end
         end
         OP_MUL: begin
            c1_rs  = sa ^ sb;
            c1_zs  = sa ^ sb;
            c1_exp = $signed({5'd0, ea}) + $signed({5'd0, eb}) - 10'sd15;
            c1_x   = {3'd0, ma};
            c1_y   = {3'd0, mb};
            if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
               c1_spec = 1'b1;
               c1_spv  = QNAN;
            end else if (a_inf || b_inf) begin
               c1_spec = 1'b1;
               c1_spv  = {sa ^ sb, INF};
            end
         end
         default: begin
            c1_rs  = sa ^ sb;
            c1_zs  = sa ^ sb;
            c1_exp = $signed({5'd0, ea}) - $signed({5'd0, eb}) + 10'sd15;
            c1_x   = {3'd0, ma};
            c1_y   = {3'd0, mb};
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
               c1_spec = 1'b1;
               c1_spv  = QNAN;
            end else if (a_inf || b_zero) begin
               c1_spec = 1'b1;
               c1_spv  = {sa ^ sb, INF};
            end else if (b_inf) begin
               c1_spec = 1'b1;
               c1_spv  = {sa ^ sb, 15'd0};
            end
         end
      endcase
   end

   op_e               r1_op;
   logic              r1_sub, r1_spec, r1_rs, r1_zs;
   logic [15:0]       r1_spv;
   logic signed [9:0] r1_exp;
   logic [13:0]       r1_x, r1_y;

   always_ff @(posedge clk) begin
      if (areset) begin
         r1_op   <= OP_ADD;
         r1_sub  <= 1'b0;
         r1_spec <= 1'b0;
         r1_rs   <= 1'b0;
         r1_zs   <= 1'b0;
         r1_spv  <= '0;
         r1_exp  <= '0;
         r1_x    <= '0;
         r1_y    <= '0;
      end else begin
         r1_op   <= in_op;
         r1_sub  <= c1_sub;
         r1_spec <= c1_spec;
         r1_rs   <= c1_rs;
         r1_zs   <= c1_zs;
         r1_spv  <= c1_spv;
         r1_exp  <= c1_exp;
         r1_x    <= c1_x;
         r1_y    <= c1_y;
      end
   end

   // ---------------- stage 2: mantissa add/sub, multiply, divide ----------------
   // c2_m carries two integer bits at [23:22]; value = c2_m * 2^-22 * 2^(exp-15)
   logic [14:0] sum;
   logic [21:0] prod;
   logic [23:0] num, rem;
   logic [13:0] quo;
   logic [10:0] den;
   logic [23:0] c2_m;
   logic        c2_stk;

   always_comb begin
      sum    = r1_sub ? ({1'b0, r1_x} - {1'b0, r1_y}) : ({1'b0, r1_x} + {1'b0, r1_y});
      prod   = {11'd0, r1_x[10:0]} * {11'd0, r1_y[10:0]};
      num    = {r1_x[10:0], 13'd0};
      den    = (r1_y[10:0] == '0) ? 11'd1 : r1_y[10:0];
      quo    = 14'(num / {13'd0, den});
      rem    = num % {13'd0, den};
      c2_m   = '0;
      c2_stk = 1'b0;
      case (r1_op)
         OP_ADD, OP_SUB: c2_m = {sum, 9'd0};
         OP_MUL:         c2_m = {prod, 2'd0};
         default: begin
            c2_m   = {1'b0, quo, 9'd0};
            c2_stk = (rem != '0);
         end
      endcase
   end

   logic              r2_spec, r2_rs, r2_zs, r2_stk;
   logic [15:0]       r2_spv;
   logic signed [9:0] r2_exp;
   logic [23:0]       r2_m;

   always_ff @(posedge clk) begin
      if (areset) begin
         r2_spec <= 1'b0;
         r2_rs   <= 1'b0;
         r2_zs   <= 1'b0;
         r2_stk  <= 1'b0;
         r2_spv  <= '0;
         r2_exp  <= '0;
         r2_m    <= '0;
      end else begin
         r2_spec <= r1_spec;
         r2_rs   <= r1_rs;
         r2_zs   <= r1_zs;
         r2_stk  <= c2_stk;
         r2_spv  <= r1_spv;
         r2_exp  <= r1_exp;
         r2_m    <= c2_m;
      end
   end

   // ---------------- stage 3: normalize, round, pack ----------------
   logic [4:0]        lz;
   logic [22:0]       n;
   logic signed [9:0] e3;
   logic              g, st;
   logic [11:0]       rnd;
   logic [9:0]        frac;
   logic [15:0]       res;

   always_comb begin
      lz = '0;
      for (int unsigned i = 0; i < 23; i++)
         if (r2_m[i]) lz = 5'(22 - i);
      if (r2_m[23]) begin
         n  = 23'(r2_m >> 1);
         e3 = r2_exp + 10'sd1;
         st = r2_stk | r2_m[0];
      end else begin
         n  = 23'(r2_m << lz);
         e3 = r2_exp - $signed({5'd0, lz});
         st = r2_stk;
      end
      g    = n[11];
      st   = st | (|n[10:0]);
      rnd  = {1'b0, n[22:12]} + {11'd0, g & (st | n[12])};
      if (rnd[11]) e3 = e3 + 10'sd1;
      frac = rnd[11] ? rnd[10:1] : rnd[9:0];

      if (r2_spec)            res = r2_spv;
      else if (r2_m == '0)    res = {r2_zs, 15'd0};
      else if (e3 > 10'sd30)  res = {r2_rs, INF};
      else if (e3 < 10'sd1)   res = {r2_rs, 15'd0};
      else                    res = {r2_rs, e3[4:0], frac};
   end

   always_ff @(posedge clk) begin
      if (areset) fpResult <= '0;
      else        fpResult <= vld[LATENCY-1] ? res : '0;
   end

endmodule

// File: tb/tb_floating_point.sv
// Directed self-checking bench for floating_point: reset, latency, pipelining,
// rounding, overflow, special values and reset in flight.
module tb_floating_point;

   logic        clk;
   logic        areset;
   logic [15:0] a, b;
   logic [1:0]  sel;
   logic [15:0] fpResult;

   int tests  = 0;
   int failed = 0;

   floating_point #(.LATENCY(3)) dut (
      .clk               (clk),
      .areset            (areset),
      .a                 (a),
      .b                 (b),
      .selectFPOperation (sel),
      .fpResult          (fpResult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] va;
      logic [15:0] vb;
      logic [1:0]  op;
      logic [15:0] want;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC] = '{
      '{16'h3C00, 16'h1000, 2'b00, 16'h3C00},  // tie rounds to even
      '{16'h3C00, 16'h1001, 2'b00, 16'h3C01},  // above tie rounds up
      '{16'h7BFF, 16'h7BFF, 2'b00, 16'h7C00},  // overflow
      '{16'h3C00, 16'h0000, 2'b11, 16'h7C00},
      '{16'h0000, 16'h0000, 2'b11, 16'h7E00},
      '{16'h7E00, 16'h3C00, 2'b10, 16'h7E00},
      '{16'hBC00, 16'h4000, 2'b10, 16'hC000},
      '{16'h3C00, 16'h3E00, 2'b01, 16'hB800},  // 1 - 1.5 = -0.5
      '{16'h8000, 16'h8000, 2'b00, 16'h8000},  // -0 + -0
      '{16'h7C00, 16'h7C00, 2'b01, 16'h7E00},  // inf - inf
      '{16'h7C00, 16'h0000, 2'b10, 16'h7E00},  // inf * 0
      '{16'hBC00, 16'h7C00, 2'b11, 16'h8000},  // -1 / inf
      '{16'h3C00, 16'h4200, 2'b11, 16'h3555},  // 1 / 3
      '{16'h3C01, 16'h3C01, 2'b10, 16'h3C02},  // product rounds down
      '{16'h8400, 16'h0400, 2'b10, 16'h8000},  // underflow flushes
      '{16'h0001, 16'h3C00, 2'b00, 16'h3C00},  // subnormal input as zero
      '{16'hFC00, 16'h3C00, 2'b00, 16'hFC00},  // -inf + 1
      '{16'h7800, 16'h7800, 2'b10, 16'h7C00},  // product overflow
      '{16'h8000, 16'h3C00, 2'b10, 16'h8000},  // -0 * 1
      '{16'h4000, 16'h8000, 2'b11, 16'hFC00}   // 2 / -0
   };

   logic [15:0] basic_exp [4] = '{16'h4500, 16'h0000, 16'h4640, 16'h3C00};
   logic [15:0] prev;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] vs);
      a   = va;
      b   = vb;
      sel = vs;
   endtask

   task automatic check(input string tag, input logic [15:0] want);
      tests++;
      assert (fpResult === want) else begin
         failed++;
         $error("FAIL %s: fpResult=%h expected=%h", tag, fpResult, want);
      end
   endtask

   initial begin
      areset = 1'b1;
      apply(16'h0000, 16'h0000, 2'b00);
      tick();
      tick();
      check("reset", 16'h0000);
      areset = 1'b0;
      repeat (5) tick();
      check("post_reset_zero", 16'h0000);

      // each op held; result must not change before the third edge after sampling
      prev = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         apply(16'h4100, 16'h4100, 2'(i));
         repeat (3) tick();
         check($sformatf("basic%0d_early", i), prev);
         tick();
         check($sformatf("basic%0d", i), basic_exp[i]);
         prev = basic_exp[i];
      end

      // select changes every cycle
      for (int i = 0; i < 4; i++) begin
         apply(16'h4100, 16'h4100, 2'(i));
         tick();
      end
      check("b2b_add", 16'h4500);
      tick();
      check("b2b_sub", 16'h0000);
      tick();
      check("b2b_mul", 16'h4640);
      tick();
      check("b2b_div", 16'h3C00);

      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i].va, vecs[i].vb, vecs[i].op);
         repeat (4) tick();
         check($sformatf("vec%0d", i), vecs[i].want);
      end

      // reset with operations in flight
      apply(16'h4100, 16'h4100, 2'b10);
      tick();
      areset = 1'b1;
      apply(16'h0000, 16'h0000, 2'b00);
      tick();
      check("reset_mid", 16'h0000);
      areset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("no_stale%0d", i), 16'h0000);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
